// File: rtl/mod_div_unit_if.sv
// Operand/result bundle for mod_div_unit.
//   master: drives start, is_signed, dividend, divisor; observes results and status.
//   slave : the divider; observes the request, drives quotient, remainder, busy,
//           done, div_zero.
interface mod_div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start,
    output is_signed,
    output dividend,
    output divisor,
    input  quotient,
    input  remainder,
    input  busy,
    input  done,
    input  div_zero
  );

  modport slave (
    input  start,
    input  is_signed,
    input  dividend,
    input  divisor,
    output quotient,
    output remainder,
    output busy,
    output done,
    output div_zero
  );

endinterface

// File: rtl/mod_div_unit.sv
// Iterative restoring divider, signed or unsigned, one quotient bit per cycle.
//
// Ports:
//   clk   - single rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - mod_div_unit_if.slave:
//           start/is_signed/dividend/divisor in (sampled on the accept edge only),
//           quotient/remainder/div_zero registered results,
//           busy (state RUN), done (state DONE).
//
// Flow: IDLE --start--> RUN for exactly WIDTH steps --> DONE, or straight to DONE
// when the divisor is zero. DONE is held while start stays high so a level start
// cannot re-trigger. Results hold until the next result load.
module mod_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mod_div_unit_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  // acc_q starts as |dividend| and fills with quotient bits from the LSB side.
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;

  // Operand magnitudes and result signs, taken straight from the bus on accept.
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  always_comb begin
    dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (WIDTH'(0) - bus.dividend) : bus.dividend;
    dvs_mag = dvs_neg ? (WIDTH'(0) - bus.divisor) : bus.divisor;
  end

  // One restoring step. The trial value {rem, next dividend bit} can reach
  // 2^(WIDTH+1)-1, so two guard bits keep the borrow visible.
  logic [WIDTH+1:0] diff;
  logic             step_ge;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;
  logic             last_step;

  always_comb begin
    diff     = {1'b0, rem_q, acc_q[WIDTH-1]} - {2'b00, dvs_q};
    step_ge  = ~diff[WIDTH+1];
    // When the subtract fails the trial value is below the divisor, so the
    // dropped rem_q MSB is known to be zero.
    shifted  = {rem_q[WIDTH-2:0], acc_q[WIDTH-1]};
    rem_step = step_ge ? diff[WIDTH-1:0] : shifted;
    acc_step = {acc_q[WIDTH-2:0], step_ge};
    // Negating a zero remainder yields zero, so no special case is needed.
    // The -2^(WIDTH-1) / -1 magnitude 2^(WIDTH-1) wraps back to itself here.
    quo_final = neg_quo_q ? (WIDTH'(0) - acc_step) : acc_step;
    rem_final = neg_rem_q ? (WIDTH'(0) - rem_step) : rem_step;
    last_step = (cnt_q == LastStep);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            cnt_q     <= '0;
            acc_q     <= dvd_mag;
            rem_q     <= '0;
            dvs_q     <= dvs_mag;
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            if (bus.divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
              div_zero_q  <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else begin
              busy_q  <= 1'b1;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          acc_q <= acc_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            quotient_q  <= quo_final;
            remainder_q <= rem_final;
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (!bus.start) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_mod_div_unit.sv
module tb_mod_div_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mod_div_unit_if #(.WIDTH(W)) bus ();

  mod_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference: plain 64-bit arithmetic. SV signed / and % truncate toward zero
  // with the remainder taking the dividend's sign.
  function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output bit dz);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      dz = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      qq = sa / sb;
      rr = sa % sb;
      q = qq[31:0];
      r = rr[31:0];
      dz = 1'b0;
    end
  endfunction

  // Issues one operation, waits (bounded) for done, returns results and timing,
  // then lets the block fall back to IDLE. lat = edges after accept until done
  // is visible, -1 on timeout.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output bit dz,
                        output int lat, output int busy_cyc, output bit overlap);
    @(negedge clk);
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    busy_cyc = 0;
    overlap = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      #1;
    end
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_zero;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Reset and a div-by-zero start in the same cycles: reset must win.
    reset = 1'b1;
    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend = 32'd5;
    bus.divisor = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 || bus.quotient !== 32'd0 ||
        bus.remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b q=%h r=%h, required all zero",
               bus.busy, bus.done, bus.div_zero, bus.quotient, bus.remainder);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r;
    bit dz, ov;
    int lat, bc;
    run_op(1'b0, 32'd100, 32'd7, q, r, dz, lat, bc, ov);
    checks++;
    if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_100_7: q=%0d r=%0d dz=%b, required 14 2 0", q, r, dz);
    end
    checks++;
    if (lat !== 32 || bc !== 32 || ov !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_timing: lat=%0d busy=%0d overlap=%b, required 32 32 0",
               lat, bc, ov);
    end
    // Now in IDLE: results must still hold.
    checks++;
    if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL hold_in_idle: q=%0d r=%0d done=%b, required 14 2 0",
               bus.quotient, bus.remainder, bus.done);
    end
  endtask

  task automatic test_signed();
    logic [31:0] q, r;
    bit dz, ov;
    int lat, bc;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, dz, lat, bc, ov);
    checks++;
    if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || dz !== 1'b0 || lat !== 32) begin
      errors++;
      $display("FAIL signed_m7_2: q=%h r=%h dz=%b lat=%0d, required fffffffd ffffffff 0 32",
               q, r, dz, lat);
    end
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, q, r, dz, lat, bc, ov);
    checks++;
    if (q !== 32'hFFFF_FFFD || r !== 32'd1 || dz !== 1'b0) begin
      errors++;
      $display("FAIL signed_7_m2: q=%h r=%h dz=%b, required fffffffd 00000001 0", q, r, dz);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r;
    bit dz, ov;
    int lat, bc;
    for (int m = 0; m < 2; m++) begin
      run_op(m[0], 32'd5, 32'd0, q, r, dz, lat, bc, ov);
      checks++;
      if (q !== 32'hFFFF_FFFF || r !== 32'd5 || dz !== 1'b1 || lat !== 0 || bc !== 0) begin
        errors++;
        $display("FAIL div_zero_mode%0d: q=%h r=%0d dz=%b lat=%0d busy=%0d, required ffffffff 5 1 0 0",
                 m, q, r, dz, lat, bc);
      end
    end
    run_op(1'b0, 32'd9, 32'd3, q, r, dz, lat, bc, ov);
    checks++;
    if (q !== 32'd3 || r !== 32'd0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL after_div_zero_9_3: q=%0d r=%0d dz=%b, required 3 0 0", q, r, dz);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r;
    bit dz, ov;
    int lat, bc;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, lat, bc, ov);
    checks++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL signed_overflow: q=%h r=%h dz=%b, required 80000000 0 0", q, r, dz);
    end
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, q, r, dz, lat, bc, ov);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_max_div1: q=%h r=%h dz=%b, required ffffffff 0 0", q, r, dz);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] q, r;
    bit dz, ov;
    int lat, bc, dones;
    @(negedge clk);
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 || bus.quotient !== 32'd0 ||
        bus.remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b dz=%b q=%h r=%h, required all zero",
               bus.busy, bus.done, bus.div_zero, bus.quotient, bus.remainder);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL aborted_no_done: active cycles=%0d, required 0", dones);
    end
    run_op(1'b0, 32'd20, 32'd6, q, r, dz, lat, bc, ov);
    checks++;
    if (q !== 32'd3 || r !== 32'd2 || dz !== 1'b0 || lat !== 32) begin
      errors++;
      $display("FAIL after_reset_20_6: q=%0d r=%0d dz=%b lat=%0d, required 3 2 0 32",
               q, r, dz, lat);
    end
  endtask

  task automatic test_held_start();
    int lat, bad, accepts;
    logic [31:0] eq, er;
    bit edz;
    @(negedge clk);
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd9;
    bus.start     = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.is_signed = 1'b1;
    bus.dividend  = 32'd77;
    bus.divisor   = 32'hFFFF_FFFB;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat < 0 || bus.quotient !== 32'd111 || bus.remainder !== 32'd1 ||
        bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL held_first_result: lat=%0d q=%0d r=%0d dz=%b, required q=111 r=1 dz=0",
               lat, bus.quotient, bus.remainder, bus.div_zero);
    end
    bad = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 32'd111) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL held_in_done: bad cycles=%0d, required 0", bad);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_release: done=%b busy=%b, required 0 0", bus.done, bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reaccept: busy=%b, required 1", bus.busy);
    end
    lat = -1;
    accepts = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i + 1;
        break;
      end
    end
    model(1'b1, 32'd77, 32'hFFFF_FFFB, eq, er, edz);
    checks++;
    if (lat !== 32 || bus.quotient !== eq || bus.remainder !== er || bus.div_zero !== edz) begin
      errors++;
      $display("FAIL reaccept_result: lat=%0d q=%h r=%h dz=%b, required 32 %h %h %b",
               lat, bus.quotient, bus.remainder, bus.div_zero, eq, er, edz);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.done) accepts++;
    end
    checks++;
    if (accepts !== 0) begin
      errors++;
      $display("FAIL single_reaccept: extra active cycles=%0d, required 0", accepts);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    bit sgn, dz, edz, ov;
    int lat, bc, elat;
    for (int n = 0; n < 60; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: begin a = 32'h8000_0000; b = $urandom; end
        4: b = 32'd0 - 32'($urandom_range(1, 1000));
        5: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 60)); end
        default: b = $urandom;
      endcase
      model(sgn, a, b, eq, er, edz);
      elat = (b == 32'd0) ? 0 : 32;
      run_op(sgn, a, b, q, r, dz, lat, bc, ov);
      checks++;
      if (q !== eq || r !== er || dz !== edz || lat !== elat || ov !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d s=%b %h/%h: q=%h r=%h dz=%b lat=%0d ov=%b, required %h %h %b %0d 0",
                 n, sgn, a, b, q, r, dz, lat, ov, eq, er, edz, elat);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_reset_mid_run();
    test_held_start();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
